// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the ALU-sharing arbiter and its requesters.
// Operands and opcodes are packed per requester: index i lives at [i*WIDTH +: WIDTH].
interface alu_share_arbiter_if #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned NUM_REQ   = 2
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*WORD_SIZE-1:0] req_a;
  logic [NUM_REQ*WORD_SIZE-1:0] req_b;
  logic [NUM_REQ*4-1:0]         req_op;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [WORD_SIZE-1:0]         rsp_result;
  logic                         rsp_zero;
  logic                         rsp_div0;
  logic                         busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_div0, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_div0, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NUM_REQ requesters.
// Operands are registered on grant, the result is registered and held until accepted.
module alu_share_arbiter #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned NUM_REQ   = 2
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam int unsigned     IdxW    = $clog2(NUM_REQ);
  localparam logic [IdxW:0]   NumReqW = (IdxW+1)'(NUM_REQ);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  localparam logic [3:0] ALU_OP_ADD = 4'h0;
  localparam logic [3:0] ALU_OP_SUB = 4'h1;
  localparam logic [3:0] ALU_OP_AND = 4'h2;
  localparam logic [3:0] ALU_OP_OR  = 4'h3;
  localparam logic [3:0] ALU_OP_XOR = 4'h4;
  localparam logic [3:0] ALU_OP_LT  = 4'h5;
  localparam logic [3:0] ALU_OP_DIV = 4'h6;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e               state_q;
  logic [IdxW-1:0]      rr_ptr_q, grant_q, gnt_idx, next_ptr;
  logic [IdxW:0]        cand;
  logic                 gnt_found;
  logic [WORD_SIZE-1:0] a_q, b_q, res_q, sel_a, sel_b, alu_res;
  logic [3:0]           op_q, sel_op;
  logic                 div0_q, busy_q, div0;
  logic [NUM_REQ-1:0]   rsp_valid_q, req_ready, grant_oh;

  // First requesting index at or above rr_ptr_q, wrapping at NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (!gnt_found && bus.req_valid[cand[IdxW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IdxW-1:0];
      end
    end
    next_ptr = (gnt_idx == LastIdx) ? '0 : gnt_idx + IdxW'(1);
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_op   = '0;
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IdxW'(i) == gnt_idx) begin
        sel_a  = bus.req_a[i*WORD_SIZE +: WORD_SIZE];
        sel_b  = bus.req_b[i*WORD_SIZE +: WORD_SIZE];
        sel_op = bus.req_op[i*4 +: 4];
      end
    end
    grant_oh[grant_q] = 1'b1;
    // Held low during reset so no requester sees an accept that cannot complete.
    req_ready = '0;
    if (rst_n && state_q == StIdle && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  // Shared ALU, fed only from the operand registers; LT is an unsigned compare.
  always_comb begin
    div0    = (op_q == ALU_OP_DIV) && (b_q == '0);
    alu_res = '0;
    case (op_q)
      ALU_OP_ADD: alu_res = a_q + b_q;
      ALU_OP_SUB: alu_res = a_q - b_q;
      ALU_OP_AND: alu_res = a_q & b_q;
      ALU_OP_OR:  alu_res = a_q | b_q;
      ALU_OP_XOR: alu_res = a_q ^ b_q;
      ALU_OP_LT:  alu_res = {{(WORD_SIZE-1){1'b0}}, (a_q < b_q)};
      ALU_OP_DIV: alu_res = div0 ? '1 : a_q / b_q;
      default:    alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      div0_q      <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_found) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            op_q     <= sel_op;
            grant_q  <= gnt_idx;
            rr_ptr_q <= next_ptr;
            busy_q   <= 1'b1;
            state_q  <= StExec;
          end
        end
        StExec: begin
          res_q       <= alu_res;
          div0_q      <= div0;
          rsp_valid_q <= grant_oh;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = (res_q == '0);
  assign bus.rsp_div0   = div0_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares a single instance of the team's combinational ALU between `NUM_REQ` requesters, such as the integer pipeline and the address-generation unit. It arbitrates round-robin and registers the winner's operands into the ALU. It then captures the result and holds it until the originating requester accepts it. Divide-by-zero is intercepted so the ALU's undefined result never propagates.

## Interface
- `WORD_SIZE`, 32: operand/result width, shared with the ALU.
- `NUM_REQ`, 2: number of requesters, 2..8.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester operation request.
- `req_ready` out NUM_REQ: per-requester accept; one-hot or zero.
- `req_a` in NUM_REQ*WORD_SIZE: operand A, requester i at bits [i*WORD_SIZE +: WORD_SIZE].
- `req_b` in NUM_REQ*WORD_SIZE: operand B, same packing.
- `req_op` in NUM_REQ*4: ALU operation code, requester i at bits [i*4 +: 4].
- `rsp_valid` out NUM_REQ: result available for requester i; one-hot or zero.
- `rsp_ready` in NUM_REQ: requester i accepts the result.
- `rsp_result` out WORD_SIZE: result of the held operation.
- `rsp_zero` out 1: `rsp_result` is all zeros.
- `rsp_div0` out 1: the held operation was ALU_OP_DIV with B == 0.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states IDLE, EXEC, RESP.
- State encoding is free. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` is set, grant the first set bit searching upward (with wrap) from `rr_ptr`.
  - Assert `req_ready[g]` combinationally for the granted requester.
  - At the edge, capture `a`, `b`, `op` and `g` into the operand registers.
  - Set `rr_ptr` to (g+1) mod NUM_REQ and go to EXEC.
  - No `req_valid` set: stay in IDLE with `req_ready` = 0.
- **EXEC:**
  - ALU inputs are driven only from the operand registers.
  - At the edge, capture the ALU result into `res_q` and set `div0_q`.
  - Go to RESP.
- **Divide-by-zero:** if `op == ALU_OP_DIV` and `b == 0`, then `res_q` = all ones and `div0_q` = 1. Otherwise `div0_q` = 0.
- **RESP:**
  - `rsp_valid[g]` = 1.
  - `rsp_result` = `res_q`.
  - `rsp_zero` = (`res_q` == 0), computed from the registered value.
  - `rsp_div0` = `div0_q`.
  - If `rsp_ready[g]` is set, go to IDLE at the edge. Otherwise hold all outputs stable.
  - `rsp_ready` bits of other requesters are ignored.
- **Requester obligations:**
  - Once `req_valid[i]` is raised, hold `a`, `b` and `op` stable and keep valid high until `req_ready[i]`.
  - Issue at most one outstanding request per requester.
- **Opcodes:** passed to the ALU unmodified, using the shared control-signal encoding. Undefined opcodes yield an unspecified `rsp_result`, but the FSM and handshake still complete normally.
- **Width:** results are truncated to WORD_SIZE exactly as the ALU produces them. ALU_OP_LT returns 0 or 1 zero-extended.
- **Outputs per state:**
  - `req_ready`: 0 outside IDLE.
  - `rsp_valid`: 0 outside RESP.
  - `busy`: 1 in EXEC and RESP.
  - `rsp_result`, `rsp_zero`, `rsp_div0`: defined only while `rsp_valid` is set.

## Timing
- **Reset values** (asynchronous on `rst_n` low, regardless of clock):
  - state = IDLE, `rr_ptr` = 0, operand registers = 0, `res_q` = 0, `div0_q` = 0, grant = 0.
  - Outputs: `req_ready` = 0, `rsp_valid` = 0, `rsp_result` = 0, `rsp_zero` = 1, `rsp_div0` = 0, `busy` = 0.
- **Reset mid-operation:** an in-flight operation is discarded and no response is issued. Requesters must re-request after reset.
- **Latency:** accept edge at T0, EXEC during T1, `rsp_valid` high from T2. The minimum request-to-response is 2 cycles.
- **Throughput:** at most one operation per 3 cycles with `rsp_ready` tied high.
- **Response back-pressure:** `rsp_ready` low holds RESP indefinitely. No new request is accepted meanwhile.
- **Simultaneous requests:** exactly one grant per IDLE cycle. A requester not granted keeps `req_valid` high and is granted within NUM_REQ acceptances.
- **No combinational path** from `rsp_ready` to `req_ready`. The only combinational path into `req_ready` is from `req_valid`.

## Test plan
- **Reset values:** assert `rst_n` low mid-clock-cycle → all outputs take their reset values immediately, with no clock needed.
- **Single ADD:**
  - Stimulus: requester 0 sends A=5, B=7, op ALU_OP_ADD; `rsp_ready` held high.
  - Required: `req_ready[0]` high in cycle T0; `rsp_valid[0]` high in T2 with result 12 and `rsp_zero` = 0; back in IDLE at T3.
- **Contention:**
  - Stimulus: requesters 0 and 1 request continuously from reset.
  - Required: grants alternate 0,1,0,1; each requester sees its own correct results, e.g. SUB 9-9 gives 0 with `rsp_zero` = 1.
- **Divide-by-zero:**
  - Stimulus: ALU_OP_DIV with A=100, B=0.
  - Required: result 0xFFFFFFFF, `rsp_div0` = 1, no X on any output.
  - Follow-up: DIV 100/7 gives 14 with `rsp_div0` = 0.
- **Back-pressure:**
  - Stimulus: hold `rsp_ready[1]` low for 5 cycles during requester 1's response while requester 0 has `req_valid` high.
  - Required: `rsp_result` is stable; `req_ready` stays 0; requester 0 is granted in the first IDLE cycle after `rsp_ready[1]` goes high.
- **Reset during EXEC:**
  - Stimulus: pulse `rst_n` low while in EXEC.
  - Required: no `rsp_valid` for the aborted operation; state is IDLE and `rr_ptr` = 0 after release.
